// File: rtl/weight_bank_control.sv
// Weight BRAM bank controller: drains the preload FIFO into BANK_NUM parallel banks
// (write mode) and presents latency-aligned bank read vectors to the MAC array (read mode).
module weight_bank_control #(
  parameter int MAC_NUM            = 256,
  parameter int WEIGHT_W           = 5,
  parameter int DATA_W             = WEIGHT_W * MAC_NUM,
  parameter int BANK_NUM           = 4,
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int FIFO_CNT_W         = 3,
  parameter int READ_LATENCY       = 2,
  parameter int SEL_W              = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_W-1:0]                      weight_from_preload,
  input  logic [FIFO_CNT_W-1:0]                  axis_fifo_cnt,
  output logic                                   axis_fifo_read,
  input  logic [BANK_NUM*DATA_W-1:0]             weight_from_bram,
  output logic [BANK_NUM*DATA_W-1:0]             weight_to_bram,
  output logic [BANK_NUM*BRAM_ADDRESS_WIDTH-1:0] bram_address,
  output logic [BANK_NUM-1:0]                    bram_en,
  output logic [BANK_NUM-1:0]                    bram_wen,
  input  logic [2:0]                             kernel_size,
  input  logic [11:0]                            output_channel_size,
  input  logic                                   write_en,
  input  logic                                   transfer_start,
  input  logic [SEL_W:0]                         rd_step,
  input  logic [SEL_W-1:0]                       port_sel,
  output logic [DATA_W-1:0]                      weight_out,
  output logic                                   weight_from_bram_valid,
  output logic                                   write_weight_finish
);

  localparam int AW    = BRAM_ADDRESS_WIDTH;
  localparam int CW    = SEL_W + 1;
  localparam int LAT_W = 3;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_FILL  = 2'd1;
  localparam logic [1:0] W_WRITE = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_VALID = 2'd2;

  logic [1:0]        w_state_reg, w_state_next;
  logic [1:0]        r_state_reg, r_state_next;
  logic [AW-1:0]     base_reg, base_next;
  logic [14:0]       word_cnt_reg, word_cnt_next;
  logic [CW-1:0]     staged_reg, staged_next;
  logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
  logic              finish_reg, finish_next;
  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] staging_reg [BANK_NUM];

  logic [2:0]        k_eff;
  logic [14:0]       total;
  logic [14:0]       remaining;
  logic [14:0]       cnt_after_beat;
  logic [CW-1:0]     target;
  logic [CW-1:0]     step_eff;
  logic              pop;
  logic              write_beat;
  logic              step_take;
  logic              beat_is_last;
  logic [SEL_W-1:0]  sel_idx;
  logic [DATA_W-1:0] bank_rd [BANK_NUM];

  // Out-of-range kernel edges degrade to a 1x1 kernel.
  assign k_eff          = (kernel_size == 3'd0 || kernel_size > 3'd5) ? 3'd1 : kernel_size;
  assign total          = 15'(output_channel_size) * 15'(k_eff);
  assign remaining      = total - word_cnt_reg;
  assign target         = (remaining >= 15'(BANK_NUM)) ? CW'(BANK_NUM) : remaining[CW-1:0];
  assign step_eff       = (rd_step > CW'(BANK_NUM)) ? CW'(BANK_NUM) : rd_step;
  assign cnt_after_beat = word_cnt_reg + 15'(staged_reg);
  assign beat_is_last   = (cnt_after_beat == total);

  // A start pulse restarts the transfer, so it suppresses any pop or write in its cycle.
  assign pop        = (w_state_reg == W_FILL) && write_en && !transfer_start &&
                      (staged_reg < target) && (axis_fifo_cnt != '0);
  assign write_beat = (w_state_reg == W_WRITE) && write_en && !transfer_start;
  assign step_take  = (r_state_reg == R_VALID) && !write_en && !transfer_start &&
                      (step_eff != '0);

  always_comb begin
    w_state_next = w_state_reg;
    if (!write_en) begin
      w_state_next = W_IDLE;
    end else if (transfer_start) begin
      w_state_next = (total == '0) ? W_IDLE : W_FILL;
    end else begin
      case (w_state_reg)
        W_FILL:  if (staged_reg == target) w_state_next = W_WRITE;
        W_WRITE: w_state_next = beat_is_last ? W_IDLE : W_FILL;
        default: w_state_next = W_IDLE;
      endcase
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    if (write_en) begin
      r_state_next = R_IDLE;
    end else if (transfer_start) begin
      r_state_next = R_WAIT;
    end else begin
      case (r_state_reg)
        R_WAIT:  if (lat_cnt_reg == LAT_W'(READ_LATENCY - 1)) r_state_next = R_VALID;
        R_VALID: if (step_eff != '0) r_state_next = R_WAIT;
        default: r_state_next = R_IDLE;
      endcase
    end
  end

  always_comb begin
    base_next     = base_reg;
    word_cnt_next = word_cnt_reg;
    staged_next   = staged_reg;
    finish_next   = finish_reg;
    if (transfer_start) begin
      base_next     = '0;
      word_cnt_next = '0;
      staged_next   = '0;
      finish_next   = write_en && (total == '0);
    end else if (!write_en) begin
      staged_next = '0;
      if (step_take) base_next = base_reg + AW'(step_eff);
    end else if (write_beat) begin
      base_next     = base_reg + AW'(staged_reg);
      word_cnt_next = cnt_after_beat;
      staged_next   = '0;
      if (beat_is_last) finish_next = 1'b1;
    end else if (pop) begin
      staged_next = staged_reg + CW'(1);
    end
  end

  // The latency counter only runs while parked in R_WAIT, so every entry starts from zero.
  assign lat_cnt_next = (r_state_reg == R_WAIT && !write_en && !transfer_start) ?
                        lat_cnt_reg + LAT_W'(1) : '0;
  assign valid_next   = (r_state_next == R_VALID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg  <= W_IDLE;
      r_state_reg  <= R_IDLE;
      base_reg     <= '0;
      word_cnt_reg <= '0;
      staged_reg   <= '0;
      lat_cnt_reg  <= '0;
      finish_reg   <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      w_state_reg  <= w_state_next;
      r_state_reg  <= r_state_next;
      base_reg     <= base_next;
      word_cnt_reg <= word_cnt_next;
      staged_reg   <= staged_next;
      lat_cnt_reg  <= lat_cnt_next;
      finish_reg   <= finish_next;
      valid_reg    <= valid_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          staging_reg[gi] <= '0;
        end else if (pop && staged_reg == CW'(gi)) begin
          staging_reg[gi] <= weight_from_preload;
        end
      end

      assign weight_to_bram[gi*DATA_W +: DATA_W] = staging_reg[gi];
      assign bram_address[gi*AW +: AW]           = base_reg + AW'(gi);
      assign bram_wen[gi]                        = write_beat && (staged_reg > CW'(gi));
      assign bram_en[gi]                         = 1'b1;
      assign bank_rd[gi]                         = weight_from_bram[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign sel_idx                = port_sel & SEL_W'(BANK_NUM - 1);
  assign weight_out             = bank_rd[sel_idx];
  assign axis_fifo_read         = pop;
  assign weight_from_bram_valid = valid_reg;
  assign write_weight_finish    = finish_reg;

endmodule

// File: doc/weight_bank_control.md
Name: weight_bank_control

Overview:
- Parametrised successor to the two-port weight BRAM controller: drives BANK_NUM weight BRAM banks in parallel. Each bank is addressed at base+i.
- Write mode: drains the AXIS preload FIFO (first-word-fall-through) into up to BANK_NUM banks per write beat.
- Read mode: issues a shared base address, waits a configurable BRAM latency, then presents the selected bank's weight vector with a valid flag.
- Sits between the preload FIFO, the weight BRAMs and the MAC array.

Parameters:
- MAC_NUM, 256, MAC lanes per weight vector.
- WEIGHT_W, 5, bits per weight; DATA_W = WEIGHT_W*MAC_NUM.
- BANK_NUM, 4, number of banks; power of two, 1..8.
- BRAM_ADDRESS_WIDTH, 12, per-bank address width.
- FIFO_CNT_W, 3, width of the FIFO occupancy count.
- READ_LATENCY, 2, BRAM read latency in cycles; 1..4.
- SEL_W, clog2(BANK_NUM) (min 1), width of bank select and step fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- weight_from_preload  in  DATA_W  FIFO head word.
- axis_fifo_cnt  in  FIFO_CNT_W  FIFO occupancy.
- axis_fifo_read  out  1  pop strobe; the head word is consumed in the same cycle.
- weight_from_bram  in  BANK_NUM*DATA_W  read data; bank i occupies slice i.
- weight_to_bram  out  BANK_NUM*DATA_W  write data per bank.
- bram_address  out  BANK_NUM*BRAM_ADDRESS_WIDTH  per-bank address = base+i, mod 2^BRAM_ADDRESS_WIDTH.
- bram_en  out  BANK_NUM  constant all-ones.
- bram_wen  out  BANK_NUM  per-bank write enable.
- kernel_size  in  3  kernel edge K, 1..5; 0 or >5 treated as 1.
- output_channel_size  in  12  output channel count C.
- write_en  in  1  selects write mode; deasserting it aborts a write.
- transfer_start  in  1  one-cycle start pulse.
- rd_step  in  SEL_W+1  read advance request, 0..BANK_NUM; 0 means no step.
- port_sel  in  SEL_W  bank whose data drives weight_out.
- weight_out  out  DATA_W  selected bank's read data, combinational from weight_from_bram.
- weight_from_bram_valid  out  1  read data valid.
- write_weight_finish  out  1  level; all words written.

Behaviour:
- Reset: base=0, both FSMs idle, staging registers and weight_to_bram = 0, wen=0, fifo_read=0, valid=0, finish=0, counters=0.
- Total words: TOTAL = C*K, 15-bit. TOTAL=0 → finish asserts one cycle after start and no FIFO pops occur.
- transfer_start (either mode): base←0, word counter←0, finish←0. It has priority over rd_step and internal address increments in the same cycle.

Write FSM (entered on transfer_start && write_en):
- W_IDLE: waits for start.
- W_FILL:
  - target = min(BANK_NUM, TOTAL−cnt).
  - While staged<target and fifo_cnt≠0: assert axis_fifo_read and latch the head word into staging slot [staged]; staged++.
  - fifo_cnt==0 → stall with no pop.
  - staged==target → W_WRITE.
- W_WRITE (one cycle):
  - bram_wen[i]=1 for i<staged, else 0.
  - base+=staged; cnt+=staged; staged←0.
  - cnt==TOTAL → finish=1, W_IDLE; otherwise W_FILL.
- write_en low in any state → W_IDLE next cycle. No wen in that cycle; staged data is discarded; finish stays 0.
- Single-beat fill (BANK_NUM=1 or target=1) is legal.

Read FSM (entered on transfer_start && !write_en):
- R_IDLE: waits for start.
- R_WAIT: counts READ_LATENCY cycles, then R_VALID.
- R_VALID:
  - valid=1.
  - rd_step≠0 → base+=rd_step, re-enter R_WAIT, valid drops next cycle.
  - transfer_start → base←0, R_WAIT.
- rd_step outside R_VALID is ignored. Values >BANK_NUM are clamped to BANK_NUM.

General:
- Base wraps modulo 2^BRAM_ADDRESS_WIDTH.
- Write and read FSMs are mutually exclusive by write_en.

Test Plan:
- BANK_NUM=4, K=1, C=6, FIFO holds 6 → two W_WRITE beats: wen=1111 at addr 0..3, then wen=0011 at addr 4..5. 6 pops; finish=1; base=6.
- FIFO empty for 3 cycles mid-fill → no pops and no wen during the stall; resumes on refill; data order preserved.
- write_en dropped after 2 pops → W_IDLE, no wen, finish=0. The next start restarts at base 0.
- Read, READ_LATENCY=2 → valid 3 cycles after start. rd_step=3 → valid low 2 cycles, then high with bank0 addr=3; port_sel=2 → weight_out = bank2 slice.
- base=4094, rd_step=4 → base=2 (wrap); bank1 address=3.
- transfer_start coincident with rd_step in R_VALID → base=0; the step is ignored.
